// File: rtl/pearson_pkg.sv
// Shared definitions for the Pearson bucket table slice.
// Contents:
//   PEARSON_HASH_W            width of the Pearson hash produced by the hasher
//   ST_MISS / ST_HIT / ST_COLL result status encodings
//   bucket_state_t            FSM state encoding of the bucket table
//   sat_inc16()               saturating 16-bit increment helper
package pearson_pkg;

  localparam int PEARSON_HASH_W = 8;

  localparam logic [1:0] ST_MISS = 2'b00;
  localparam logic [1:0] ST_HIT  = 2'b01;
  localparam logic [1:0] ST_COLL = 2'b10;

  typedef enum logic [1:0] {
    S_INIT   = 2'b00,
    S_IDLE   = 2'b01,
    S_LOOKUP = 2'b10,
    S_RESP   = 2'b11
  } bucket_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pearson_bucket_mem.sv
// Direct-mapped key storage for pearson_bucket_table.
// Each entry holds one valid bit and a KEY_W-bit key. Key bits are never
// reset; the owner invalidates entries one at a time through the clear port.
// Ports:
//   clk                          rising-edge clock
//   rd_idx / rd_valid / rd_key   asynchronous read port
//   wr_en / wr_idx / wr_key      write port: stores key and sets valid
//   clr_en / clr_idx             clear-one-entry port: drops the valid bit
// A clear and a write in the same cycle never happen in practice (they come
// from different FSM states); clear wins on the valid bit if they ever did.
module pearson_bucket_mem
  import pearson_pkg::*;
#(
  parameter int KEY_W = 8,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [KEY_W-1:0] rd_key,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx
);

  localparam int DEPTH = 1 << IDX_W;

  logic             valid_r [DEPTH];
  logic [KEY_W-1:0] key_r   [DEPTH];

  // Valid bit array: cleared by the sweep, set by an insertion.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      valid_r[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Key array: written only on insertion, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_r[wr_idx] <= wr_key;
    end
  end

  assign rd_valid = valid_r[rd_idx];
  assign rd_key   = key_r[rd_idx];

endmodule

// File: rtl/pearson_bucket_table.sv
// Pearson bucket table: uses an 8-bit Pearson hash as the index into a
// direct-mapped key table and classifies each (key, hash) pair as
// MISS (inserted), HIT (same key resident) or COLLISION (other key resident).
// Optional build macro: PEARSON_BUCKET_STATS_EN adds saturating 16-bit
// hit/miss/collision counters.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               level request to invalidate the table (IDLE only)
//   in_valid/in_ready   input handshake; in_key, in_hash carry the pair
//   out_valid/out_ready result handshake
//   out_status          00 MISS, 01 HIT, 10 COLLISION
//   out_index           table index used
//   out_stored_key      key resident at the index after the operation
//   init_done           sticky flag, set when the first sweep after reset ends
//   hit_cnt, miss_cnt, coll_cnt   (PEARSON_BUCKET_STATS_EN only)
// Flow: INIT sweeps every valid bit (2^IDX_W cycles), IDLE accepts a pair,
// LOOKUP reads/updates the entry in one cycle, RESP holds the result until
// out_ready. Peak rate is one pair every three cycles.
module pearson_bucket_table
  import pearson_pkg::*;
#(
  parameter int KEY_W = 8,
  parameter int IDX_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [KEY_W-1:0]          in_key,
  input  logic [PEARSON_HASH_W-1:0] in_hash,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                out_status,
  output logic [IDX_W-1:0]          out_index,
  output logic [KEY_W-1:0]          out_stored_key,
  output logic                      init_done
`ifdef PEARSON_BUCKET_STATS_EN
  ,
  output logic [15:0]               hit_cnt,
  output logic [15:0]               miss_cnt,
  output logic [15:0]               coll_cnt
`endif
);

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] CNT_LAST = {IDX_W{1'b1}};

  bucket_state_t    state_r, state_s;
  logic [IDX_W-1:0] cnt_r, cnt_s;
  logic [KEY_W-1:0] key_r, key_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic             out_valid_r, out_valid_s;
  logic [1:0]       status_r, status_s;
  logic [IDX_W-1:0] index_r, index_s;
  logic [KEY_W-1:0] stored_r, stored_s;
  logic             init_done_r, init_done_s;

  logic             clr_en_s;
  logic             wr_en_s;
  logic             stats_clr_s;
  logic             resp_done_s;
  logic             rd_valid_s;
  logic [KEY_W-1:0] rd_key_s;
  logic             unused_hash_s;

  // Hash bits above the index width play no part in addressing.
  assign unused_hash_s = ^in_hash;

  pearson_bucket_mem #(
    .KEY_W (KEY_W),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk      (clk),
    .rd_idx   (idx_r),
    .rd_valid (rd_valid_s),
    .rd_key   (rd_key_s),
    .wr_en    (wr_en_s),
    .wr_idx   (idx_r),
    .wr_key   (key_r),
    .clr_en   (clr_en_s),
    .clr_idx  (cnt_r)
  );

  // Next-state, datapath next values and memory strobes.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    key_s       = key_r;
    idx_s       = idx_r;
    out_valid_s = out_valid_r;
    status_s    = status_r;
    index_s     = index_r;
    stored_s    = stored_r;
    init_done_s = init_done_r;
    clr_en_s    = 1'b0;
    wr_en_s     = 1'b0;
    stats_clr_s = 1'b0;
    resp_done_s = 1'b0;
    case (state_r)
      S_INIT: begin
        clr_en_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          state_s     = S_IDLE;
          cnt_s       = IDX_ZERO;
          init_done_s = 1'b1;
        end else begin
          cnt_s = cnt_r + IDX_ONE;
        end
      end
      S_IDLE: begin
        // clear outranks a pair offered in the same cycle
        if (clear) begin
          state_s     = S_INIT;
          cnt_s       = IDX_ZERO;
          stats_clr_s = 1'b1;
        end else if (in_valid) begin
          key_s   = in_key;
          idx_s   = in_hash[IDX_W-1:0];
          state_s = S_LOOKUP;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOOKUP: begin
        out_valid_s = 1'b1;
        index_s     = idx_r;
        state_s     = S_RESP;
        if (!rd_valid_s) begin
          wr_en_s  = 1'b1;
          status_s = ST_MISS;
          stored_s = key_r;
        end else if (rd_key_s == key_r) begin
          status_s = ST_HIT;
          stored_s = rd_key_s;
        end else begin
          // resident key stays; report what is there
          status_s = ST_COLL;
          stored_s = rd_key_s;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          resp_done_s = 1'b1;
          state_s     = S_IDLE;
        end else begin
          state_s = S_RESP;
        end
      end
      default: begin
        state_s = S_INIT;
        cnt_s   = IDX_ZERO;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_INIT;
      cnt_r       <= IDX_ZERO;
      key_r       <= '0;
      idx_r       <= IDX_ZERO;
      out_valid_r <= 1'b0;
      status_r    <= ST_MISS;
      index_r     <= IDX_ZERO;
      stored_r    <= '0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      key_r       <= key_s;
      idx_r       <= idx_s;
      out_valid_r <= out_valid_s;
      status_r    <= status_s;
      index_r     <= index_s;
      stored_r    <= stored_s;
      init_done_r <= init_done_s;
    end
  end

  assign in_ready       = (state_r == S_IDLE) && !clear;
  assign out_valid      = out_valid_r;
  assign out_status     = status_r;
  assign out_index      = index_r;
  assign out_stored_key = stored_r;
  assign init_done      = init_done_r;

`ifdef PEARSON_BUCKET_STATS_EN
  logic [15:0] hit_cnt_r;
  logic [15:0] miss_cnt_r;
  logic [15:0] coll_cnt_r;

  // Result counters, bumped on each completed response handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_r  <= 16'd0;
      miss_cnt_r <= 16'd0;
      coll_cnt_r <= 16'd0;
    end else if (stats_clr_s) begin
      hit_cnt_r  <= 16'd0;
      miss_cnt_r <= 16'd0;
      coll_cnt_r <= 16'd0;
    end else if (resp_done_s) begin
      case (status_r)
        ST_MISS: miss_cnt_r <= sat_inc16(miss_cnt_r);
        ST_HIT:  hit_cnt_r  <= sat_inc16(hit_cnt_r);
        ST_COLL: coll_cnt_r <= sat_inc16(coll_cnt_r);
        default: coll_cnt_r <= coll_cnt_r;
      endcase
    end
  end

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;
  assign coll_cnt = coll_cnt_r;
`else
  logic unused_stats_s;
  assign unused_stats_s = stats_clr_s ^ resp_done_s;
`endif

endmodule

// File: tb/tb_pearson_bucket_table.sv
// Self-checking bench for pearson_bucket_table (KEY_W = 8, IDX_W = 8).
// A table model (valid/key arrays indexed by hash) predicts each result.
module tb_pearson_bucket_table;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_key;
  logic [7:0] in_hash;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_status;
  logic [7:0] out_index;
  logic [7:0] out_stored_key;
  logic       init_done;
`ifdef PEARSON_BUCKET_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
  logic [15:0] coll_cnt;
`endif

  pearson_bucket_table #(.KEY_W(8), .IDX_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear          (clear),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_key         (in_key),
    .in_hash        (in_hash),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_status     (out_status),
    .out_index      (out_index),
    .out_stored_key (out_stored_key),
    .init_done      (init_done)
`ifdef PEARSON_BUCKET_STATS_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt),
    .coll_cnt       (coll_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: what the table should contain
  bit       m_valid [256];
  bit [7:0] m_key   [256];
  int       m_hits, m_miss, m_coll;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef PEARSON_BUCKET_STATS_EN
    check({tag, "_hit"},  32'(hit_cnt),  32'(m_hits));
    check({tag, "_miss"}, 32'(miss_cnt), 32'(m_miss));
    check({tag, "_coll"}, 32'(coll_cnt), 32'(m_coll));
`else
    n_chk = n_chk + 0;
`endif
  endtask

  // Count cycles with in_ready low until the sweep ends (bounded).
  task automatic wait_sweep(input string tag, input int already);
    int cyc;
    bit saw_ov;
    bit early_done;
    cyc = already;
    saw_ov = 1'b0;
    early_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid) saw_ov = 1'b1;
      if (in_ready) break;
      if (init_done && tag == "boot") early_done = 1'b1;
    end
    check({tag, "_sweep_len"}, 32'(cyc), 32'd256);
    check({tag, "_init_done"}, 32'(init_done), 32'd1);
    check({tag, "_no_ov"}, 32'(saw_ov), 32'd0);
    check({tag, "_done_early"}, 32'(early_done), 32'd0);
  endtask

  // Offer one pair, check the result, hold out_ready low for 'hold' cycles.
  task automatic do_pair(input logic [7:0] key, input logic [7:0] hash,
                         input int hold, input bit pend);
    logic [1:0] e_st;
    logic [7:0] e_key;
    int idx;
    idx = int'(hash);
    if (!m_valid[idx]) begin
      e_st = 2'b00; m_valid[idx] = 1'b1; m_key[idx] = key; m_miss++;
    end else if (m_key[idx] == key) begin
      e_st = 2'b01; m_hits++;
    end else begin
      e_st = 2'b10; m_coll++;
    end
    e_key = m_key[idx];
    check("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_key = key; in_hash = hash;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("lat_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("out_valid", 32'(out_valid), 32'd1);
    check("status", 32'(out_status), 32'(e_st));
    check("index", 32'(out_index), 32'(hash));
    check("stored_key", 32'(out_stored_key), 32'(e_key));
    for (int h = 0; h < hold; h++) begin
      if (pend) begin
        in_valid = 1'b1; in_key = 8'h55; in_hash = 8'h99;
      end
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_status", 32'(out_status), 32'(e_st));
      check("hold_key", 32'(out_stored_key), 32'(e_key));
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ov_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] rk;
    logic [7:0] rh;
    logic [7:0] hset [4];
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_key = 8'h00;
    in_hash = 8'h00; out_ready = 1'b0;
    m_hits = 0; m_miss = 0; m_coll = 0;
    model_clear();
    hset[0] = 8'h00; hset[1] = 8'hFF; hset[2] = 8'h17; hset[3] = 8'h80;

    // reset values
    #23;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_status", 32'(out_status), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_stored", 32'(out_stored_key), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check_stats("rst");
    rst_n = 1'b1;
    wait_sweep("boot", 0);

    // miss, hit, collision, hit again
    do_pair(8'h41, 8'h17, 0, 1'b0);
    do_pair(8'h41, 8'h17, 0, 1'b0);
    do_pair(8'h42, 8'h17, 0, 1'b0);
    do_pair(8'h41, 8'h17, 0, 1'b0);
    check_stats("sc3");

    // back-pressure with a pending pair
    do_pair(8'h10, 8'hFF, 5, 1'b1);
    check("pend_ready_after", 32'(in_ready), 32'd1);
    do_pair(8'h55, 8'h99, 0, 1'b0);

    // randomized pairs on a few crowded indices
    for (int n = 0; n < 24; n++) begin
      rk = 8'h60 + 8'($urandom_range(0, 3));
      rh = hset[$urandom_range(0, 3)];
      do_pair(rk, rh, int'($urandom_range(0, 2)), 1'b0);
    end
    check_stats("rand");

    // clear and in_valid together: clear wins
    clear = 1'b1; in_valid = 1'b1; in_key = 8'h77; in_hash = 8'h33;
    @(posedge clk); #1;
    check("clr_ready", 32'(in_ready), 32'd0);
    clear = 1'b0; in_valid = 1'b0;
    model_clear();
    m_hits = 0; m_miss = 0; m_coll = 0;
    wait_sweep("clear", 0);
    check_stats("clr");
    do_pair(8'h41, 8'h17, 0, 1'b0);
    do_pair(8'h77, 8'h33, 0, 1'b0);

    // reset during RESP
    in_valid = 1'b1; in_key = 8'h41; in_hash = 8'h17;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_ov", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ov", 32'(out_valid), 32'd0);
    check("async_done", 32'(init_done), 32'd0);
    model_clear();
    m_hits = 0; m_miss = 0; m_coll = 0;
    check_stats("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    wait_sweep("reboot", 0);
    do_pair(8'h41, 8'h17, 0, 1'b0);
    check_stats("end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
